rtc_capture_bank: RTL and testbench

- Parametrised successor to the 11-byte RTC register bank.
- Captures one data byte per read-strobe slot from the RTC bus sequencer into a working bank.
- On frame completion, commits the working bank atomically into a shadow bank, so the VGA side always sees one coherent frame.
- Provides a random-access read port and a free-running scan serializer with an active-low frame-sync pulse.

---
 rtl/rtc_capture_bank.sv | 144 ++++++++++++++
 tb/tb_rtc_capture_bank.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/rtc_capture_bank.sv
// rtc_capture_bank
//   Captures one RTC data byte per accepted read strobe into a working bank
//   and commits the whole bank atomically into a shadow bank when a frame
//   completes. The shadow bank is exposed through a registered random-access
//   read port and a free-running scan serializer with an active-low sync.
//
// Ports
//   clk          system clock, rising edge
//   reset        asynchronous active-low reset
//   data_in      RTC bus read data
//   bus_active   bus sequencer busy; gates strobe acceptance
//   bus_count    bus sequencer phase counter (capture window / strobe gate)
//   read_n       active-low read strobe, asynchronous to clk
//   clear        synchronous soft clear (shadow bank retained)
//   rd_idx       random-access read index
//   rd_data      shadow[rd_idx], one cycle latency, 0 when out of range
//   cur_idx      current capture slot, 0 = idle
//   frame_valid  shadow holds at least one committed frame
//   frame_done   one-cycle pulse on commit
//   scan_idx     serializer position 0..NUM_REGS
//   scan_data    shadow[scan_idx], 0 at scan_idx==NUM_REGS
//   scan_sync_n  low only while scan_idx==NUM_REGS
module rtc_capture_bank #(
    parameter int DATA_W   = 8,
    parameter int NUM_REGS = 11,
    parameter int IDX_W    = 4,
    parameter int CNT_W    = 8,
    parameter logic [CNT_W-1:0] WIN_LO     = 8'h18,
    parameter logic [CNT_W-1:0] WIN_HI     = 8'h1E,
    parameter logic [CNT_W-1:0] STROBE_MIN = 8'd37
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] data_in,
    input  logic              bus_active,
    input  logic [CNT_W-1:0]  bus_count,
    input  logic              read_n,
    input  logic              clear,
    input  logic [IDX_W-1:0]  rd_idx,
    output logic [DATA_W-1:0] rd_data,
    output logic [IDX_W-1:0]  cur_idx,
    output logic              frame_valid,
    output logic              frame_done,
    output logic [IDX_W-1:0]  scan_idx,
    output logic [DATA_W-1:0] scan_data,
    output logic              scan_sync_n
);

    localparam logic [IDX_W-1:0] LP_LAST = IDX_W'(NUM_REGS);

    logic              r_s0, r_s1, r_s2;
    logic [DATA_W-1:0] r_work   [NUM_REGS];
    logic [DATA_W-1:0] r_shadow [NUM_REGS];
    logic [IDX_W-1:0]  r_cur;
    logic              r_fv;
    logic              r_done;
    logic [DATA_W-1:0] r_rd;
    logic [IDX_W-1:0]  r_scan_idx;
    logic [DATA_W-1:0] r_scan_data;
    logic              r_sync_n;

    logic              w_fall;
    logic              w_acc;
    logic              w_commit;
    logic              w_cap;
    logic [IDX_W-1:0]  w_scan_nxt;
    logic [DATA_W-1:0] w_work_nxt [NUM_REGS];

    // s2 is the oldest sample: a high->low step between s2 and s1 is a fall.
    assign w_fall   = r_s2 & ~r_s1;
    assign w_acc    = w_fall & bus_active & (bus_count > STROBE_MIN);
    assign w_commit = w_acc & (r_cur == LP_LAST);
    assign w_cap    = (r_cur != '0) & (bus_count >= WIN_LO) & (bus_count <= WIN_HI);

    assign w_scan_nxt = (r_scan_idx == LP_LAST) ? '0 : r_scan_idx + 1'b1;

    // Working bank as it will be after this edge; the commit copies this so
    // a capture landing on the commit edge is part of the committed frame.
    always_comb begin
        w_work_nxt = r_work;
        if (w_cap) begin
            w_work_nxt[r_cur - 1'b1] = data_in;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_s0        <= 1'b1;
            r_s1        <= 1'b1;
            r_s2        <= 1'b1;
            r_cur       <= '0;
            r_fv        <= 1'b0;
            r_done      <= 1'b0;
            r_rd        <= '0;
            r_scan_idx  <= '0;
            r_scan_data <= '0;
            r_sync_n    <= 1'b1;
            for (int i = 0; i < NUM_REGS; i++) begin
                r_work[i]   <= '0;
                r_shadow[i] <= '0;
            end
        end else begin
            r_s0   <= read_n;
            r_s1   <= r_s0;
            r_s2   <= r_s1;
            r_done <= 1'b0;

            if (clear) begin
                r_cur <= '0;
                r_fv  <= 1'b0;
                for (int i = 0; i < NUM_REGS; i++) begin
                    r_work[i] <= '0;
                end
            end else begin
                r_work <= w_work_nxt;
                if (w_acc) begin
                    // 0 -> 1 and n -> n+1 share the increment; wrap only on commit.
                    r_cur <= w_commit ? IDX_W'(1) : r_cur + 1'b1;
                end
                if (w_commit) begin
                    r_shadow <= w_work_nxt;
                    r_fv     <= 1'b1;
                    r_done   <= 1'b1;
                end
            end

            r_rd <= (rd_idx < LP_LAST) ? r_shadow[rd_idx] : '0;

            // Scanner reads the pre-commit shadow, so a register never tears.
            r_scan_idx  <= w_scan_nxt;
            r_scan_data <= (w_scan_nxt < LP_LAST) ? r_shadow[w_scan_nxt] : '0;
            r_sync_n    <= (w_scan_nxt != LP_LAST);
        end
    end

    assign rd_data     = r_rd;
    assign cur_idx     = r_cur;
    assign frame_valid = r_fv;
    assign frame_done  = r_done;
    assign scan_idx    = r_scan_idx;
    assign scan_data   = r_scan_data;
    assign scan_sync_n = r_sync_n;

endmodule

// File: tb/tb_rtc_capture_bank.sv
module tb_rtc_capture_bank;
    localparam int N = 11;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [7:0] data_in = '0;
    logic       bus_active = 1'b0;
    logic [7:0] bus_count = '0;
    logic       read_n = 1'b1;
    logic       clear = 1'b0;
    logic [3:0] rd_idx = '0;
    logic [7:0] rd_data;
    logic [3:0] cur_idx;
    logic       frame_valid;
    logic       frame_done;
    logic [3:0] scan_idx;
    logic [7:0] scan_data;
    logic       scan_sync_n;

    rtc_capture_bank dut (
        .clk(clk), .reset(reset), .data_in(data_in), .bus_active(bus_active),
        .bus_count(bus_count), .read_n(read_n), .clear(clear), .rd_idx(rd_idx),
        .rd_data(rd_data), .cur_idx(cur_idx), .frame_valid(frame_valid),
        .frame_done(frame_done), .scan_idx(scan_idx), .scan_data(scan_data),
        .scan_sync_n(scan_sync_n)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_bad = 0;

    // Reference model: frame-level state only.
    logic [7:0] m_work   [N];
    logic [7:0] m_shadow [N];
    int         m_cur;
    bit         m_fv;

    // Edges since reset release; scanner position is this count mod N+1.
    int scan_m;
    always @(posedge clk or negedge reset)
        if (!reset) scan_m <= 0;
        else        scan_m <= scan_m + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h want=%0h", tag, obs, exp);
        end
    endtask

    function automatic void m_reset();
        for (int i = 0; i < N; i++) begin
            m_work[i] = '0;
            m_shadow[i] = '0;
        end
        m_cur = 0;
        m_fv = 0;
    endfunction

    function automatic bit m_strobe(input bit act, input int cnt);
        if (!(act && cnt > 37)) return 0;
        if (m_cur == N) begin
            m_shadow = m_work;
            m_cur = 1;
            m_fv = 1;
            return 1;
        end
        m_cur++;
        return 0;
    endfunction

    task automatic align();
        @(posedge clk); #1;
    endtask

    task automatic strobe(input bit act, input logic [7:0] cnt);
        int pulses = 0;
        bit commit;
        align();
        bus_active = act;
        bus_count = cnt;
        read_n = 1'b0;
        repeat (4) begin
            @(negedge clk); if (frame_done) pulses++;
            @(posedge clk); #1;
        end
        read_n = 1'b1;
        bus_active = 1'b0;
        bus_count = '0;
        repeat (3) begin
            @(negedge clk); if (frame_done) pulses++;
            @(posedge clk); #1;
        end
        commit = m_strobe(act, int'(cnt));
        chk("done_pulses", pulses, commit ? 1 : 0);
        chk("cur_idx", cur_idx, m_cur);
    endtask

    task automatic window(input logic [7:0] d, input logic [7:0] cnt);
        align();
        data_in = d;
        bus_count = cnt;
        align();
        bus_count = '0;
        if (m_cur != 0 && cnt >= 8'h18 && cnt <= 8'h1E) m_work[m_cur-1] = d;
    endtask

    task automatic rd_chk(input int idx);
        align();
        rd_idx = 4'(idx);
        @(posedge clk);
        @(negedge clk);
        chk($sformatf("rd[%0d]", idx), rd_data, (idx < N) ? m_shadow[idx] : 8'h00);
    endtask

    task automatic do_clear();
        align();
        clear = 1'b1;
        align();
        clear = 1'b0;
        m_cur = 0;
        m_fv = 0;
        for (int i = 0; i < N; i++) m_work[i] = '0;
        chk("clr_cur", cur_idx, 0);
        chk("clr_fv", frame_valid, 0);
        chk("clr_done", frame_done, 0);
    endtask

    task automatic scan_sweep(input string tag);
        repeat (N + 1) begin
            @(negedge clk);
            chk({tag, "_idx"}, scan_idx, scan_m % (N + 1));
            chk({tag, "_sync"}, scan_sync_n, (scan_idx != N));
            chk({tag, "_data"}, scan_data, (scan_idx < N) ? m_shadow[scan_idx] : 8'h00);
        end
    endtask

    initial begin
        int op;
        m_reset();
        // Reset asserted from time 0; outputs must already be cleared.
        #12;
        chk("rst_cur", cur_idx, 0);
        chk("rst_fv", frame_valid, 0);
        chk("rst_sync", scan_sync_n, 1);
        chk("rst_scan", scan_idx, 0);
        #11 reset = 1'b1;
        align();
        chk("idle_cur", cur_idx, 0);
        chk("idle_fv", frame_valid, 0);
        scan_sweep("idle");
        scan_sweep("idle2");

        // One full frame plus the committing strobe.
        for (int s = 1; s <= N; s++) begin
            strobe(1'b1, 8'd40);
            window(8'hA0 + 8'(s), 8'h18);
        end
        strobe(1'b1, 8'd40);
        chk("frame_fv", frame_valid, 1);
        for (int i = 0; i < N; i++) begin
            rd_chk(i);
            chk("frame_lit", rd_data, 8'hA1 + 8'(i));
        end
        chk("frame_cur", cur_idx, 1);
        scan_sweep("frame");

        // Rejected strobes, then acceptance-latency check at bus_count=38.
        strobe(1'b1, 8'd37);
        strobe(1'b0, 8'd40);
        align();
        bus_active = 1'b1;
        bus_count = 8'd38;
        read_n = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("lat_2", cur_idx, m_cur);
        @(posedge clk); #1;
        chk("lat_3", cur_idx, m_cur + 1);
        align();
        read_n = 1'b1;
        bus_active = 1'b0;
        bus_count = '0;
        repeat (3) align();
        void'(m_strobe(1'b1, 38));

        // Slot 2: last in-window sample wins, out-of-window ignored.
        chk("slot2", cur_idx, 2);
        window(8'h11, 8'h18);
        window(8'h22, 8'h1B);
        window(8'h33, 8'h1E);
        window(8'h44, 8'h1F);
        while (m_cur != N) begin
            strobe(1'b1, 8'd40);
            window(8'($urandom), 8'h1A);
        end
        strobe(1'b1, 8'd40);
        rd_chk(1);
        chk("last_wins", rd_data, 8'h33);

        // Clear at slot 6.
        while (m_cur != 6) strobe(1'b1, 8'd50);
        do_clear();
        for (int i = 0; i < N; i++) rd_chk(i);
        strobe(1'b1, 8'd40);
        chk("restart", cur_idx, 1);

        // Randomized mix against the model.
        for (int k = 0; k < 300; k++) begin
            op = $urandom_range(0, 39);
            if (op == 0) do_clear();
            else if (op <= 17) strobe($urandom_range(0, 3) != 0, 8'($urandom_range(32, 255)));
            else if (op <= 33) window(8'($urandom), 8'($urandom_range(16, 37)));
            else rd_chk($urandom_range(0, 15));
        end
        chk("rand_fv", frame_valid, m_fv);
        scan_sweep("rand");

        // Async reset mid-frame.
        do_clear();
        repeat (3) strobe(1'b1, 8'd40);
        @(posedge clk); #3;
        reset = 1'b0;
        #1;
        m_reset();
        chk("arst_cur", cur_idx, 0);
        chk("arst_fv", frame_valid, 0);
        chk("arst_done", frame_done, 0);
        chk("arst_rd", rd_data, 0);
        chk("arst_scan", scan_idx, 0);
        chk("arst_sdata", scan_data, 0);
        chk("arst_sync", scan_sync_n, 1);
        #7 reset = 1'b1;
        rd_chk(0);
        rd_chk(5);
        rd_chk(12);
        chk("rd12", rd_data, 0);
        scan_sweep("post_rst");

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout got=%0d want=%0d", 1, 0);
        $fatal(1, "timeout");
    end
endmodule
